// File: rtl/pwm_capture.sv
// pwm_capture: receive-side timestamping of a deserialized PWM line.
// Each clk delivers N = 1<<HRBITS samples (din_i[N-1] earliest) plus the coarse
// timebase. Edges are timestamped as {tb, sample index}, and per PWM cycle the
// rise-to-rise period and rise-to-fall high time are reported.
// Optional feature macro: PWMCAP_AVG_EN. When defined, results are averaged over
// 2^AVG_LOG consecutive cycles and meas_valid_o pulses once per group.
module pwm_capture #(
    parameter int WIDTH   = 17,
    parameter int HRBITS  = 3,
    parameter int TMO     = 4095
`ifdef PWMCAP_AVG_EN
    ,
    parameter int AVG_LOG = 4
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-HRBITS-1:0]  tb_i,
    input  logic [(1<<HRBITS)-1:0]   din_i,
    input  logic                     clr_i,
    output logic                     meas_valid_o,
    output logic [WIDTH-1:0]         period_o,
    output logic [WIDTH-1:0]         high_time_o,
    output logic                     stuck_o,
    output logic                     level_o,
    output logic                     glitch_err_o
);

    localparam int N  = 1 << HRBITS;
    localparam int CW = WIDTH - HRBITS;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_C = TW'(TMO);

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        WAIT_FALL = 2'd1,
        WAIT_RISE = 2'd2
    } state_e;

    // Stage 1 registers
    logic [N-1:0]     din_q;
    logic [CW-1:0]    tb_q;

    // Stage 2 state
    logic             prev_q;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] rise_ts_q, rise_ts_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             stuck_q, stuck_d;
    logic             glitch_q, glitch_d;

    // Output registers
    logic             meas_valid_q, meas_valid_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;

    // Edge scan results
    logic [N:0]        seq;
    logic              rise_found, fall_found;
    logic              rise_multi, fall_multi;
    logic [HRBITS-1:0] rise_idx, fall_idx;
    logic [WIDTH-1:0]  rise_ts, fall_ts;

    // Up to two events per word, in sample order
    logic              ev_vld     [2];
    logic              ev_is_rise [2];
    logic [WIDTH-1:0]  ev_ts      [2];

    logic              timeout_hit;
    logic              done;
    logic [WIDTH-1:0]  done_period, done_high;

    // Stage 1: register the sample word and timebase together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            din_q <= '1;
            tb_q  <= '0;
        end else begin
            din_q <= din_i;
            tb_q  <= tb_i;
        end
    end

    // Find the first rise and first fall in the word; flag repeats as glitches
    always_comb begin
        seq        = {prev_q, din_q};
        rise_found = 1'b0;
        fall_found = 1'b0;
        rise_multi = 1'b0;
        fall_multi = 1'b0;
        rise_idx   = '0;
        fall_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!seq[N-i] && seq[N-1-i]) begin
                if (rise_found) begin
                    rise_multi = 1'b1;
                end else begin
                    rise_found = 1'b1;
                    rise_idx   = i[HRBITS-1:0];
                end
            end
            if (seq[N-i] && !seq[N-1-i]) begin
                if (fall_found) begin
                    fall_multi = 1'b1;
                end else begin
                    fall_found = 1'b1;
                    fall_idx   = i[HRBITS-1:0];
                end
            end
        end
        rise_ts = {tb_q, rise_idx};
        fall_ts = {tb_q, fall_idx};
    end

    // Order the two events by sample index (they can never share an index)
    always_comb begin
        ev_vld[0]     = 1'b0;
        ev_vld[1]     = 1'b0;
        ev_is_rise[0] = 1'b0;
        ev_is_rise[1] = 1'b0;
        ev_ts[0]      = '0;
        ev_ts[1]      = '0;
        if (rise_found && fall_found) begin
            ev_vld[0] = 1'b1;
            ev_vld[1] = 1'b1;
            if (rise_idx < fall_idx) begin
                ev_is_rise[0] = 1'b1;
                ev_ts[0]      = rise_ts;
                ev_ts[1]      = fall_ts;
            end else begin
                ev_is_rise[1] = 1'b1;
                ev_ts[0]      = fall_ts;
                ev_ts[1]      = rise_ts;
            end
        end else if (rise_found) begin
            ev_vld[0]     = 1'b1;
            ev_is_rise[0] = 1'b1;
            ev_ts[0]      = rise_ts;
        end else if (fall_found) begin
            ev_vld[0] = 1'b1;
            ev_ts[0]  = fall_ts;
        end
    end

    // Timeout counter: any rise clears it, otherwise count up and saturate at TMO
    always_comb begin
        if (rise_found) begin
            cnt_d = '0;
        end else if (cnt_q == TMO_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
        timeout_hit = !rise_found && (cnt_d == TMO_C);
        if (rise_found) begin
            stuck_d = 1'b0;
        end else if (timeout_hit) begin
            stuck_d = 1'b1;
        end else begin
            stuck_d = stuck_q;
        end
        if (rise_mult_or_fall()) begin
            glitch_d = 1'b1;
        end else if (clr_i) begin
            glitch_d = 1'b0;
        end else begin
            glitch_d = glitch_q;
        end
    end

    function automatic logic rise_mult_or_fall();
        return rise_multi | fall_multi;
    endfunction

    // Measurement FSM: walk the word's events in sample order
    always_comb begin
        state_d     = state_q;
        rise_ts_d   = rise_ts_q;
        high_d      = high_q;
        done        = 1'b0;
        done_period = '0;
        done_high   = '0;
        for (int k = 0; k < 2; k++) begin
            if (ev_vld[k]) begin
                case (state_d)
                    SYNC: begin
                        if (ev_is_rise[k]) begin
                            rise_ts_d = ev_ts[k];
                            state_d   = WAIT_FALL;
                        end
                    end
                    WAIT_FALL: begin
                        if (ev_is_rise[k]) begin
                            // a rise with no fall in between only happens via a
                            // glitch; restart the cycle from the new rise
                            rise_ts_d = ev_ts[k];
                        end else begin
                            high_d  = ev_ts[k] - rise_ts_d;
                            state_d = WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (ev_is_rise[k]) begin
                            done        = 1'b1;
                            done_period = ev_ts[k] - rise_ts_d;
                            done_high   = high_d;
                            rise_ts_d   = ev_ts[k];
                            state_d     = WAIT_FALL;
                        end
                    end
                    default: state_d = SYNC;
                endcase
            end
        end
        if (timeout_hit) begin
            state_d = SYNC;
        end
    end

    // Stage 2 state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q    <= 1'b1;
            state_q   <= SYNC;
            rise_ts_q <= '0;
            high_q    <= '0;
            cnt_q     <= '0;
            stuck_q   <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            prev_q    <= din_q[0];
            state_q   <= state_d;
            rise_ts_q <= rise_ts_d;
            high_q    <= high_d;
            cnt_q     <= cnt_d;
            stuck_q   <= stuck_d;
            glitch_q  <= glitch_d;
        end
    end

`ifdef PWMCAP_AVG_EN
    localparam int AW = WIDTH + AVG_LOG;

    logic [AW-1:0]      acc_p_q, acc_p_d;
    logic [AW-1:0]      acc_h_q, acc_h_d;
    logic [AVG_LOG-1:0] avg_cnt_q, avg_cnt_d;
    logic [AW-1:0]      sum_p, sum_h;

    // Accumulate completed cycles; publish the truncated mean once per group
    always_comb begin
        meas_valid_d = 1'b0;
        period_d     = period_q;
        high_time_d  = high_time_q;
        acc_p_d      = acc_p_q;
        acc_h_d      = acc_h_q;
        avg_cnt_d    = avg_cnt_q;
        sum_p        = acc_p_q + AW'(done_period);
        sum_h        = acc_h_q + AW'(done_high);
        if (timeout_hit) begin
            acc_p_d   = '0;
            acc_h_d   = '0;
            avg_cnt_d = '0;
        end else if (done) begin
            if (avg_cnt_q == '1) begin
                meas_valid_d = 1'b1;
                period_d     = sum_p[AW-1:AVG_LOG];
                high_time_d  = sum_h[AW-1:AVG_LOG];
                acc_p_d      = '0;
                acc_h_d      = '0;
                avg_cnt_d    = '0;
            end else begin
                acc_p_d   = sum_p;
                acc_h_d   = sum_h;
                avg_cnt_d = avg_cnt_q + AVG_LOG'(1);
            end
        end
    end

    // Averaging accumulators
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_p_q   <= '0;
            acc_h_q   <= '0;
            avg_cnt_q <= '0;
        end else begin
            acc_p_q   <= acc_p_d;
            acc_h_q   <= acc_h_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`else
    // Publish every completed cycle directly
    always_comb begin
        meas_valid_d = done;
        period_d     = done ? done_period : period_q;
        high_time_d  = done ? done_high : high_time_q;
    end
`endif

    // Output registers; period/high time hold between pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
        end else begin
            meas_valid_q <= meas_valid_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
        end
    end

    assign meas_valid_o = meas_valid_q;
    assign period_o     = period_q;
    assign high_time_o  = high_time_q;
    assign stuck_o      = stuck_q;
    assign level_o      = prev_q;
    assign glitch_err_o = glitch_q;

endmodule
